// File: rtl/ifetch.sv
// rtl/ifetch.sv - single-stage instruction fetch with IF/ID register, redirect and stall handling
module ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misalign,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_misalign_q, out_misalign_d;
    logic        mis_pend_q, mis_pend_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        load;
    logic        handshake;

    assign load      = fetch_en && (!out_valid_q || out_ready) && !redirect_valid;
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_instr_d    = out_instr_q;
        out_misalign_d = out_misalign_q;
        mis_pend_d     = mis_pend_q;
        fetch_cnt_d    = handshake ? fetch_cnt_q + 32'd1 : fetch_cnt_q;

        // A redirect squashes the stage even if decode takes it this cycle; the handshake still counts.
        if (redirect_valid) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            mis_pend_d  = (redirect_pc[1:0] != 2'b00);
        end else if (load) begin
            out_instr_d    = imem_rdata;
            out_pc_d       = pc_q;
            out_valid_d    = 1'b1;
            out_misalign_d = mis_pend_q;
            mis_pend_d     = 1'b0;
            pc_d           = pc_q + 32'd4;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_pc_q       <= 32'd0;
            out_instr_q    <= NOP_INSTR;
            out_misalign_q <= 1'b0;
            mis_pend_q     <= 1'b0;
            fetch_cnt_q    <= 32'd0;
        end else begin
            pc_q           <= pc_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_instr_q    <= out_instr_d;
            out_misalign_q <= out_misalign_d;
            mis_pend_q     <= mis_pend_d;
            fetch_cnt_q    <= fetch_cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_instr    = out_instr_q;
    assign out_misalign = out_misalign_q;
    assign fetch_cnt    = fetch_cnt_q;

endmodule
